// File: rtl/vram_dma_if.sv
// vram_dma_if: CPU register port plus VRAM port-A bundle for vram_dma.
// slave is the DMA engine side, master the system/CPU side.
interface vram_dma_if;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dout;
   logic        cpu_wr_n;
   logic        cpu_rd_n;
   logic        cpu_vram_cs;
   logic        reg_cs;
   logic [7:0]  reg_data_out;
   logic        dma_grant;
   logic [15:0] dma_addr;
   logic        dma_wr;
   logic [7:0]  dma_data;
   logic [7:0]  dma_din;
   logic        busy;
   logic        done;
   logic        irq_n;

   modport slave (
      input  cpu_addr, cpu_dout, cpu_wr_n, cpu_rd_n,
      input  cpu_vram_cs, dma_din,
      output reg_cs, reg_data_out, dma_grant, dma_addr,
      output dma_wr, dma_data, busy, done, irq_n
   );

   modport master (
      output cpu_addr, cpu_dout, cpu_wr_n, cpu_rd_n,
      output cpu_vram_cs, dma_din,
      input  reg_cs, reg_data_out, dma_grant, dma_addr,
      input  dma_wr, dma_data, busy, done, irq_n
   );
endinterface

// File: rtl/vram_dma.sv
// vram_dma: fill/copy engine for the char/colour VRAMs, uses spare port-A cycles.
// Define VRAM_DMA_IRQ_EN to drive irq_n low while done_sticky is set.
module vram_dma #(
   parameter logic [7:0] BASE_PAGE = 8'h8C
) (
   input logic       clk_24,
   input logic       reset_n,
   vram_dma_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE,
      FILL_WR,
      CP_RD,
      CP_CAP,
      CP_WR,
      FINISH
   } state_t;

   state_t state, state_nx;

   logic [15:0] src_r, dst_r, len_r;
   logic [7:0]  fill_r;
   logic [15:0] src_w, dst_w, len_w;
   logic [15:0] src_nx, dst_nx, len_nx;
   logic [7:0]  latch_r, latch_nx;
   logic        wr_n_q, rd_n_q;
   logic        done_r, done_sticky;
   logic [2:0]  ofs;
   logic        sel, wr_stb, rd_stb, ctrl_wr, stat_rd;
   logic        start_req, abort_req;
   logic        busy_w, req, grant;
   logic [15:0] addr_o;
   logic [7:0]  data_o, rdata;
   logic        wr_o;
   logic        unused_bits;

   assign unused_bits = ^bus.cpu_addr[7:3];

   assign ofs       = bus.cpu_addr[2:0];
   assign sel       = bus.cpu_addr[15:8] == BASE_PAGE;
   assign wr_stb    = sel & ~bus.cpu_wr_n & wr_n_q;
   assign rd_stb    = sel & ~bus.cpu_rd_n & rd_n_q;
   assign ctrl_wr   = wr_stb & (ofs == 3'd7);
   assign stat_rd   = rd_stb & (ofs == 3'd7);
   assign abort_req = ctrl_wr & bus.cpu_dout[2];
   assign start_req = ctrl_wr & bus.cpu_dout[0]
                    & ~bus.cpu_dout[2];

   assign busy_w = state != IDLE;
   assign req    = state inside {FILL_WR, CP_RD, CP_WR};
   assign grant  = req & ~bus.cpu_vram_cs;

   // Strobes fire on the falling edge of the Z80 strobes only.
   always_ff @(posedge clk_24 or negedge reset_n) begin
      if (!reset_n) begin
         wr_n_q <= 1'b1;
         rd_n_q <= 1'b1;
      end else begin
         wr_n_q <= bus.cpu_wr_n;
         rd_n_q <= bus.cpu_rd_n;
      end
   end

   always_ff @(posedge clk_24 or negedge reset_n) begin
      if (!reset_n) begin
         src_r  <= '0;
         dst_r  <= '0;
         len_r  <= '0;
         fill_r <= '0;
      end else if (wr_stb && !busy_w) begin
         unique case (ofs)
            3'd0: src_r[7:0]  <= bus.cpu_dout;
            3'd1: src_r[15:8] <= bus.cpu_dout;
            3'd2: dst_r[7:0]  <= bus.cpu_dout;
            3'd3: dst_r[15:8] <= bus.cpu_dout;
            3'd4: len_r[7:0]  <= bus.cpu_dout;
            3'd5: len_r[15:8] <= bus.cpu_dout;
            3'd6: fill_r      <= bus.cpu_dout;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_24 or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         src_w   <= '0;
         dst_w   <= '0;
         len_w   <= '0;
         latch_r <= '0;
      end else begin
         state   <= state_nx;
         src_w   <= src_nx;
         dst_w   <= dst_nx;
         len_w   <= len_nx;
         latch_r <= latch_nx;
      end
   end

   always_comb begin
      state_nx = state;
      src_nx   = src_w;
      dst_nx   = dst_w;
      len_nx   = len_w;
      latch_nx = latch_r;
      wr_o     = 1'b0;
      addr_o   = '0;
      data_o   = '0;
      unique case (state)
         IDLE: begin
            if (start_req) begin
               src_nx = src_r;
               dst_nx = dst_r;
               len_nx = len_r;
               if (len_r == 16'd0)
                  state_nx = FINISH;
               else if (bus.cpu_dout[1])
                  state_nx = CP_RD;
               else
                  state_nx = FILL_WR;
            end
         end
         FILL_WR: begin
            if (abort_req) begin
               state_nx = FINISH;
            end else if (grant) begin
               wr_o   = 1'b1;
               addr_o = dst_w;
               data_o = fill_r;
               dst_nx = dst_w + 16'd1;
               len_nx = len_w - 16'd1;
               if (len_w == 16'd1)
                  state_nx = FINISH;
            end
         end
         CP_RD: begin
            if (abort_req) begin
               state_nx = FINISH;
            end else if (grant) begin
               addr_o   = src_w;
               state_nx = CP_CAP;
            end
         end
         // RAM output now holds the byte addressed in CP_RD.
         CP_CAP: begin
            if (abort_req) begin
               state_nx = FINISH;
            end else begin
               latch_nx = bus.dma_din;
               src_nx   = src_w + 16'd1;
               state_nx = CP_WR;
            end
         end
         CP_WR: begin
            if (abort_req) begin
               state_nx = FINISH;
            end else if (grant) begin
               wr_o   = 1'b1;
               addr_o = dst_w;
               data_o = latch_r;
               dst_nx = dst_w + 16'd1;
               len_nx = len_w - 16'd1;
               state_nx = (len_w == 16'd1) ? FINISH : CP_RD;
            end
         end
         FINISH: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_24 or negedge reset_n) begin
      if (!reset_n) begin
         done_r      <= 1'b0;
         done_sticky <= 1'b0;
      end else begin
         done_r <= state == FINISH;
         if (state == FINISH)
            done_sticky <= 1'b1;
         else if (stat_rd)
            done_sticky <= 1'b0;
      end
   end

   always_comb begin
      rdata = 8'h00;
      unique case (ofs)
         3'd0: rdata = src_r[7:0];
         3'd1: rdata = src_r[15:8];
         3'd2: rdata = dst_r[7:0];
         3'd3: rdata = dst_r[15:8];
         3'd4: rdata = len_r[7:0];
         3'd5: rdata = len_r[15:8];
         3'd6: rdata = fill_r;
         3'd7: rdata = {6'd0, done_sticky, busy_w};
      endcase
   end

   assign bus.reg_cs       = sel;
   assign bus.reg_data_out = rdata;
   assign bus.dma_grant    = grant;
   assign bus.dma_addr     = addr_o;
   assign bus.dma_wr       = wr_o;
   assign bus.dma_data     = data_o;
   assign bus.busy         = busy_w;
   assign bus.done         = done_r;

`ifdef VRAM_DMA_IRQ_EN
   assign bus.irq_n = ~done_sticky;
`else
   assign bus.irq_n = 1'b1;
`endif
endmodule

// File: doc/vram_dma.md
Name: vram_dma

Overview:
- CPU-programmable fill/copy engine for the character-map VRAMs: char index RAM 0x9800–0x9FFF, fg colour RAM 0xA000–0xA7FF, bg colour RAM 0xA800–0xAFFF.
- Shares the CPU-side port (port A) of those dprams with the Z80. The CPU always has priority; DMA uses only the cycles the CPU leaves free.
- Sits in the system module beside the address decoder. Its register page joins the CPU data mux. Its address/data/write outputs are muxed onto VRAM port A while dma_grant is high.

Parameters:
- BASE_PAGE, 8'h8C, cpu_addr[15:8] value that selects the register page.

Ports:
- clk_24  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_addr  in  16  Z80 address bus
- cpu_dout  in  8  Z80 write data
- cpu_wr_n  in  1  Z80 write strobe, active low
- cpu_vram_cs  in  1  CPU is addressing chram, fgcolram or bgcolram this cycle
- reg_cs  out  1  register page decode, for the system data mux
- reg_data_out  out  8  register readback
- dma_grant  out  1  DMA owns VRAM port A this cycle
- dma_addr  out  16  VRAM address; the system decodes which RAM it selects
- dma_wr  out  1  VRAM write enable; only ever high while dma_grant is high
- dma_data  out  8  VRAM write data
- dma_din  in  8  port A read data of the RAM selected by dma_addr (1-cycle registered latency)
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when a transfer completes or is aborted
- irq_n  out  1  see Optional Feature

Behaviour:
- Clock and reset: one clock, clk_24. reset_n is asynchronous and active-low.
- Reset values: all registers 0, state IDLE, busy=0, done=0, dma_grant=0, dma_wr=0, dma_addr=0, dma_data=0, irq_n=1.
- reg_cs = (cpu_addr[15:8]==BASE_PAGE). Only cpu_addr[2:0] is decoded inside the page.
- Write strobe: reg_cs & ~cpu_wr_n & (cpu_wr_n was high last cycle). Each Z80 write acts exactly once.
- Register map, offsets 0–7:
  - 0/1: SRC lo/hi
  - 2/3: DST lo/hi
  - 4/5: LEN lo/hi
  - 6: FILL value
  - 7: CTRL on write — bit0 START, bit1 MODE (0=fill, 1=copy), bit2 ABORT
  - 7: STATUS on read — {6'b0, done_sticky, busy}. done_sticky clears on a STATUS read (reg_cs & ~cpu_rd_n edge, offset 7).
  - Offsets 0–6 read back as written.
- Writes to offsets 0–6 while busy are ignored. START while busy is ignored.
- States:
  - IDLE
  - FILL_WR
  - CP_RD
  - CP_CAP
  - CP_WR
  - FINISH
- Transitions:
  - START with LEN==0: IDLE→FINISH. No VRAM access.
  - START, fill mode: IDLE→FILL_WR. Working copies of SRC/DST/LEN are loaded.
  - FILL_WR, granted: dma_addr=DST, dma_data=FILL, dma_wr=1, DST++, LEN--. When LEN reaches 0, →FINISH.
  - CP_RD, granted: dma_addr=SRC, then →CP_CAP.
  - CP_CAP: never requests the port. Captures dma_din into the data latch, SRC++, →CP_WR.
  - CP_WR, granted: dma_addr=DST, dma_data=latch, dma_wr=1, DST++, LEN--. Then →CP_RD, or →FINISH when LEN reaches 0.
  - FINISH: done=1 for one cycle, done_sticky=1, →IDLE.
- Arbitration:
  - dma_grant = (state ∈ {FILL_WR, CP_RD, CP_WR}) & ~cpu_vram_cs, combinational.
  - In a non-granted cycle the state, pointers and LEN hold, and dma_wr=0.
- Throughput with no contention: fill is 1 cycle/byte; copy is 3 cycles/byte. busy is high from the cycle after START through FINISH inclusive.
- Address arithmetic: 16-bit, wraps 0xFFFF→0x0000. No range checking; writes outside the VRAMs fall on no RAM.
- ABORT (any state except IDLE): →FINISH next cycle. No further writes. The working registers keep their partial values.
- START and ABORT in the same write: ABORT wins; if IDLE, nothing starts.
- Reset asserted mid-transfer: immediate return to the reset values. No partial write is issued after reset asserts.

Optional Feature:
- Macro: VRAM_DMA_IRQ_EN.
- Defined: irq_n is driven low from FINISH until done_sticky clears (STATUS read or reset). The system ties it to the Z80 int_n.
- Undefined: irq_n is constant 1 and no interrupt logic is synthesised. done_sticky still operates.

Test Plan:
- Fill: DST=0x9800, LEN=16, FILL=0x20, CTRL=0x01 → 16 consecutive dma_wr pulses to 0x9800..0x980F with data 0x20. busy lasts 17 cycles, done pulses once, STATUS reads 0x02.
- Copy: preload 0xA000..0xA003 = 11,22,33,44; SRC=0xA000, DST=0xA800, LEN=4, CTRL=0x03 → 0xA800..0xA803 = 11,22,33,44; 12 transfer cycles plus FINISH.
- Contention: fill LEN=4 with cpu_vram_cs held high for 5 cycles mid-transfer → dma_grant=0 and dma_wr=0 in those cycles. The same 4 writes occur, delayed by exactly 5 cycles.
- LEN=0 start → no dma_wr; done pulses 2 cycles after the strobe. Second START while busy (LEN=100) → ignored; exactly 100 writes occur.
- ABORT after 3 fill writes → no 4th write, done pulses, busy=0. Then reset_n low mid-copy → all outputs at reset values asynchronously.
- VRAM_DMA_IRQ_EN defined: irq_n goes low at FINISH and returns high after a STATUS read. Undefined: irq_n stays 1 throughout.
